// File: rtl/mm_pkg.sv
// Shared matrix-multiply types for the result drainer.
// Provides the signed element type, array edge length, row type and the
// drainer phase encoding.
// Optional build macro used by result_drainer: DRAINER_RELU_EN.
package mm_pkg;

  localparam int unsigned SYS_ARRAY_LEN = 8;
  localparam int unsigned NUMBER_W      = 16;

  typedef logic signed [NUMBER_W-1:0] NUMBER;

  typedef NUMBER Row [SYS_ARRAY_LEN];

  typedef enum logic {
    Drainer_Collect = 1'b0,
    Drainer_Serve   = 1'b1
  } DrainerState;

endpackage

// File: rtl/row_regfile.sv
// Row-wide register file: DEPTH rows of WIDTH bits, one write port and one
// registered read port.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (read regs only)
//   we/waddr/wdata  synchronous row write
//   rd_en/raddr   read request; answered on the next cycle
//   rdata/rvalid  registered read data and its one-cycle valid pulse
module row_regfile
  import mm_pkg::*;
#(
  parameter int unsigned DEPTH  = SYS_ARRAY_LEN,
  parameter int unsigned WIDTH  = SYS_ARRAY_LEN * NUMBER_W,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses (non-power-of-two depth) read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= (32'(raddr) < DEPTH) ? mem[raddr] : '0;
      end
    end
  end

endmodule

// File: rtl/result_drainer.sv
// Result drainer: captures LEN deskewed result rows from the systolic array
// (COLLECT), then serves them to the bus one row per read (SERVE) until
// cleared.
// Optional build macro: DRAINER_RELU_EN clamps negative elements to zero
// on capture.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   row handshake from the deskew stage
//   data_in             one result row, element j at [j*DATA_W +: DATA_W]
//   cs/rd_en/raddr      bus read request
//   rdata/rvalid        registered read response, 1-cycle latency
//   result_ready        full matrix captured and readable
//   clear               release buffer, return to COLLECT
//   overflow            sticky: row offered while not ready
module result_drainer
  import mm_pkg::*;
#(
  parameter int unsigned LEN    = SYS_ARRAY_LEN,
  parameter int unsigned DATA_W = NUMBER_W,
  parameter int unsigned ADDR_W = $clog2(LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LEN*DATA_W-1:0] data_in,
  input  logic                  cs,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [LEN*DATA_W-1:0] rdata,
  output logic                  rvalid,
  output logic                  result_ready,
  input  logic                  clear,
  output logic                  overflow
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(LEN - 1);

  DrainerState           state;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [LEN*DATA_W-1:0] capture_row;
  logic                  row_we;
  logic                  row_rd;

  // Element clamp on the capture path (sign bit test only, no extra stage).
  always_comb begin
    capture_row = data_in;
`ifdef DRAINER_RELU_EN
    for (int j = 0; j < int'(LEN); j++) begin
      if (data_in[j*DATA_W + DATA_W - 1]) begin
        capture_row[j*DATA_W +: DATA_W] = '0;
      end
    end
`endif
  end

  // clear beats a simultaneous row; reads are only honoured while serving.
  assign row_we = (state == Drainer_Collect) && in_valid && !clear;
  assign row_rd = (state == Drainer_Serve) && cs && rd_en;

  // Phase FSM, write pointer and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= Drainer_Collect;
      wr_ptr       <= '0;
      in_ready     <= 1'b1;
      result_ready <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      case (state)
        Drainer_Collect: begin
          if (clear) begin
            wr_ptr <= '0;
          end else if (in_valid) begin
            if (wr_ptr == LAST_ROW) begin
              state        <= Drainer_Serve;
              wr_ptr       <= '0;
              in_ready     <= 1'b0;
              result_ready <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
          end
        end
        Drainer_Serve: begin
          if (clear) begin
            state        <= Drainer_Collect;
            wr_ptr       <= '0;
            in_ready     <= 1'b1;
            result_ready <= 1'b0;
          end
        end
        default: begin
          state <= Drainer_Collect;
        end
      endcase
    end
  end

  row_regfile #(
    .DEPTH  (LEN),
    .WIDTH  (LEN * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (row_we),
    .waddr  (wr_ptr),
    .wdata  (capture_row),
    .rd_en  (row_rd),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

endmodule

// File: tb/tb_result_drainer.sv
// Testbench for result_drainer: randomized rows and reads checked against a
// queue-based model of the capture/serve behaviour.
// Honours DRAINER_RELU_EN in the model's capture rule.
module tb_result_drainer;

  localparam int LEN = 8;
  localparam int DW  = 16;
  localparam int AW  = 3;

  typedef logic [LEN*DW-1:0] row_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  row_t          data_in;
  logic          cs;
  logic          rd_en;
  logic [AW-1:0] raddr;
  row_t          rdata;
  logic          rvalid;
  logic          result_ready;
  logic          clear;
  logic          overflow;

  result_drainer #(.LEN(LEN), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .cs           (cs),
    .rd_en        (rd_en),
    .raddr        (raddr),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .result_ready (result_ready),
    .clear        (clear),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: rows accepted so far, the published matrix, and the held rdata.
  row_t mdl_buf [LEN];
  row_t pending [$];
  bit   mdl_ready;
  row_t last_rdata;
  row_t stim [LEN];

  function automatic row_t capture(input row_t r);
    row_t o;
    o = r;
`ifdef DRAINER_RELU_EN
    for (int j = 0; j < LEN; j++) begin
      if ($signed(r[j*DW +: DW]) < 0) o[j*DW +: DW] = '0;
    end
`endif
    return o;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int j = 0; j < LEN; j++) r[j*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input row_t r);
    if (!mdl_ready) begin
      pending.push_back(capture(r));
      if (pending.size() == LEN) begin
        for (int i = 0; i < LEN; i++) mdl_buf[i] = pending[i];
        pending.delete();
        mdl_ready = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    pending.delete();
    mdl_ready = 1'b0;
  endtask

  task automatic fill(input int gap);
    for (int r = 0; r < LEN; r++) begin
      data_in  = stim[r];
      in_valid = 1'b1;
      tick();
      model_accept(stim[r]);
      in_valid = 1'b0;
      checks++;
      if (result_ready !== mdl_ready || in_ready !== !mdl_ready)
        $display("FAIL fill_status row=%0d result_ready=%b in_ready=%b expected %b/%b",
                 r, result_ready, in_ready, mdl_ready, !mdl_ready);
      else passed++;
      if (r < LEN - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          checks++;
          if (result_ready !== 1'b0)
            $display("FAIL gap_ready row=%0d result_ready=%b expected 0", r, result_ready);
          else passed++;
        end
      end
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < LEN; i++) begin
      cs = 1'b1; rd_en = 1'b1; raddr = AW'(i);
      tick();
      last_rdata = mdl_buf[i];
      checks++;
      if (rvalid !== 1'b1 || rdata !== mdl_buf[i])
        $display("FAIL read_row addr=%0d rvalid=%b rdata=%h expected 1/%h",
                 i, rvalid, rdata, mdl_buf[i]);
      else passed++;
    end
    cs = 1'b0; rd_en = 1'b0;
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== last_rdata)
      $display("FAIL read_idle rvalid=%b rdata=%h expected 0/%h", rvalid, rdata, last_rdata);
    else passed++;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || result_ready !== 1'b0 || rvalid !== 1'b0 ||
        rdata !== '0 || overflow !== 1'b0)
      $display("FAIL reset_values in_ready=%b result_ready=%b rvalid=%b rdata=%h overflow=%b",
               in_ready, result_ready, rvalid, rdata, overflow);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    last_rdata = '0;
    tick();
  endtask

  task automatic test_fill_read();
    for (int r = 0; r < LEN; r++)
      for (int j = 0; j < LEN; j++) stim[r][j*DW +: DW] = DW'(10 * r + j);
    fill(0);
    read_all();
  endtask

  task automatic test_random_reads();
    bit c, e;
    int a;
    for (int n = 0; n < 40; n++) begin
      c = 1'($urandom); e = 1'($urandom); a = $urandom_range(LEN - 1);
      cs = c; rd_en = e; raddr = AW'(a);
      tick();
      if (c && e) last_rdata = mdl_buf[a];
      checks++;
      if (rvalid !== (c && e) || rdata !== last_rdata)
        $display("FAIL random_read n=%0d rvalid=%b rdata=%h expected %b/%h",
                 n, rvalid, rdata, c && e, last_rdata);
      else passed++;
    end
    cs = 1'b0; rd_en = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    row_t fives;
    row_t row3;
    for (int j = 0; j < LEN; j++) fives[j*DW +: DW] = DW'(5);
    for (int j = 0; j < LEN; j++) row3[j*DW +: DW] = DW'(30 + j);
    data_in = fives; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || result_ready !== 1'b1)
      $display("FAIL overflow_set overflow=%b result_ready=%b expected 1/1", overflow, result_ready);
    else passed++;
    tick(); tick();
    checks++;
    if (overflow !== 1'b1)
      $display("FAIL overflow_sticky overflow=%b expected 1", overflow);
    else passed++;
    cs = 1'b1; rd_en = 1'b1; raddr = AW'(3);
    tick();
    cs = 1'b0; rd_en = 1'b0;
    last_rdata = row3;
    checks++;
    if (rvalid !== 1'b1 || rdata !== row3)
      $display("FAIL overflow_row3 rvalid=%b rdata=%h expected 1/%h", rvalid, rdata, row3);
    else passed++;
  endtask

  task automatic test_clear_race();
    cs = 1'b1; rd_en = 1'b1; raddr = AW'(2); clear = 1'b1;
    tick();
    cs = 1'b0; rd_en = 1'b0; clear = 1'b0;
    last_rdata = mdl_buf[2];
    model_clear();
    checks++;
    if (rvalid !== 1'b1 || rdata !== last_rdata || result_ready !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clear_race rvalid=%b rdata=%h result_ready=%b in_ready=%b expected 1/%h/0/1",
               rvalid, rdata, result_ready, in_ready, last_rdata);
    else passed++;
    cs = 1'b1; rd_en = 1'b1; raddr = AW'(5);
    tick();
    cs = 1'b0; rd_en = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || rdata !== last_rdata)
      $display("FAIL collect_read rvalid=%b rdata=%h expected 0/%h", rvalid, rdata, last_rdata);
    else passed++;
    for (int r = 0; r < LEN; r++) stim[r] = rand_row();
    fill(2);
    read_all();
    checks++;
    if (overflow !== 1'b1)
      $display("FAIL overflow_hold overflow=%b expected 1", overflow);
    else passed++;
  endtask

  task automatic test_clear_in_collect();
    do_clear();
    for (int r = 0; r < 3; r++) begin
      data_in = rand_row(); in_valid = 1'b1;
      tick();
      model_accept(data_in);
    end
    data_in = rand_row(); clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    model_clear();
    checks++;
    if (result_ready !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL collect_clear result_ready=%b in_ready=%b expected 0/1", result_ready, in_ready);
    else passed++;
    for (int r = 0; r < LEN; r++) stim[r] = rand_row();
    fill($urandom_range(1));
    read_all();
  endtask

  task automatic test_reset_mid_fill();
    do_clear();
    for (int r = 0; r < 4; r++) begin
      data_in = rand_row(); in_valid = 1'b1;
      tick();
      model_accept(data_in);
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    last_rdata = '0;
    checks++;
    if (in_ready !== 1'b1 || result_ready !== 1'b0 || rvalid !== 1'b0 ||
        rdata !== '0 || overflow !== 1'b0)
      $display("FAIL async_reset in_ready=%b result_ready=%b rvalid=%b rdata=%h overflow=%b",
               in_ready, result_ready, rvalid, rdata, overflow);
    else passed++;
    #3;
    rst_n = 1'b1;
    tick();
    for (int r = 0; r < LEN; r++) stim[r] = rand_row();
    fill(0);
    read_all();
  endtask

  task automatic test_clamp();
    row_t expect_row;
    int   raw [LEN];
    raw = '{-3, 0, 7, -32768, 100, -1, 32767, -200};
    do_clear();
    for (int r = 0; r < LEN; r++) stim[r] = rand_row();
    for (int j = 0; j < LEN; j++) begin
      stim[0][j*DW +: DW] = DW'(raw[j]);
`ifdef DRAINER_RELU_EN
      expect_row[j*DW +: DW] = (raw[j] < 0) ? '0 : DW'(raw[j]);
`else
      expect_row[j*DW +: DW] = DW'(raw[j]);
`endif
    end
    fill(1);
    cs = 1'b1; rd_en = 1'b1; raddr = '0;
    tick();
    cs = 1'b0; rd_en = 1'b0;
    last_rdata = expect_row;
    checks++;
    if (rvalid !== 1'b1 || rdata !== expect_row)
      $display("FAIL clamp_row rvalid=%b rdata=%h expected 1/%h", rvalid, rdata, expect_row);
    else passed++;
    read_all();
  endtask

  initial begin
    in_valid = 1'b0; data_in = '0; cs = 1'b0; rd_en = 1'b0;
    raddr = '0; clear = 1'b0; rst_n = 1'b0;
    test_reset();
    test_fill_read();
    test_random_reads();
    test_overflow();
    test_clear_race();
    test_clear_in_collect();
    test_reset_mid_fill();
    test_random_reads();
    test_clamp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d checks=%0d", passed, checks);
    $fatal(1);
  end

endmodule
